fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/common_pkg.sv | 16 +
 rtl/pipes_pkg.sv | 24 ++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared bus types used across the pipeline: address type and the
// instruction-bus request/response channels.
package common;
    typedef logic [63:0] addr_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } ibus_resp_t;
endpackage

// File: rtl/pipes_pkg.sv
// Pipeline-stage definitions: fetch FSM states, the fetch->decode payload
// and the default reset PC.
package pipes;
    import common::*;

    localparam addr_t PCINIT = 64'h8000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        addr_t       pc;
        logic [31:0] raw_instr;
    } fetch_data_t;

    // Sequential successor; the add wraps naturally at 2^64.
    function automatic addr_t pc_next(input addr_t pc);
        return pc + 64'd4;
    endfunction
endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding bus request, a one-entry stall
// buffer, and branch redirect with wrong-path squash.
module fetch_unit
    import common::*;
#(
    parameter addr_t PCINIT = pipes::PCINIT
) (
    input  logic              clk,
    input  logic              reset,
    output ibus_req_t         ireq,
    input  ibus_resp_t        iresp,
    output pipes::fetch_data_t dataF,
    input  logic              stallF,
    input  logic              branch,
    input  addr_t             PCbranch
);

    pipes::fetch_state_t r_state, w_state_n;
    pipes::fetch_data_t  r_data, w_data_n;
    addr_t               r_pc, w_pc_n;
    addr_t               r_drop_addr, w_drop_addr_n;
    addr_t               r_buf_pc, w_buf_pc_n;
    logic [31:0]         r_buf_instr, w_buf_instr_n;
    logic                w_honor;
    logic                w_unused;

    // A redirect is only meaningful when decode is accepting.
    assign w_honor  = branch & ~stallF;
    assign dataF    = r_data;
    assign w_unused = ^{iresp.addr_ok, iresp.data[63:32]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= pipes::FETCH;
            r_pc        <= PCINIT;
            r_data      <= '0;
            r_drop_addr <= '0;
            r_buf_pc    <= '0;
            r_buf_instr <= '0;
        end else begin
            r_state     <= w_state_n;
            r_pc        <= w_pc_n;
            r_data      <= w_data_n;
            r_drop_addr <= w_drop_addr_n;
            r_buf_pc    <= w_buf_pc_n;
            r_buf_instr <= w_buf_instr_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_pc_n        = r_pc;
        w_data_n      = r_data;
        w_drop_addr_n = r_drop_addr;
        w_buf_pc_n    = r_buf_pc;
        w_buf_instr_n = r_buf_instr;
        ireq          = '0;
        // An accepting decode sees an empty slot unless something is delivered below.
        if (!stallF) begin
            w_data_n.valid = 1'b0;
        end

        case (r_state)
            pipes::FETCH: begin
                ireq.valid = 1'b1;
                ireq.addr  = r_pc;
                if (w_honor) begin
                    w_pc_n = PCbranch;
                    if (!iresp.data_ok) begin
                        w_state_n     = pipes::DROP;
                        w_drop_addr_n = r_pc;
                    end
                end else if (iresp.data_ok) begin
                    if (stallF) begin
                        w_buf_pc_n    = r_pc;
                        w_buf_instr_n = iresp.data[31:0];
                        w_state_n     = pipes::HOLD;
                    end else begin
                        w_data_n = {1'b1, r_pc, iresp.data[31:0]};
                        w_pc_n   = pipes::pc_next(r_pc);
                    end
                end
            end
            pipes::DROP: begin
                // The wrong-path request must still complete on the bus.
                ireq.valid = 1'b1;
                ireq.addr  = r_drop_addr;
                if (w_honor) begin
                    w_pc_n = PCbranch;
                end
                if (iresp.data_ok) begin
                    w_state_n = pipes::FETCH;
                end
            end
            pipes::HOLD: begin
                if (w_honor) begin
                    w_pc_n        = PCbranch;
                    w_buf_pc_n    = '0;
                    w_buf_instr_n = '0;
                    w_state_n     = pipes::FETCH;
                end else if (!stallF) begin
                    w_data_n  = {1'b1, r_buf_pc, r_buf_instr};
                    w_pc_n    = pipes::pc_next(r_buf_pc);
                    w_state_n = pipes::FETCH;
                end
            end
            default: begin
                w_state_n = pipes::FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a simple latency-programmable bus responder.
module tb_fetch_unit;
    import common::*;
    import pipes::*;

    logic              clk;
    logic              reset;
    ibus_req_t         ireq;
    ibus_resp_t        iresp;
    fetch_data_t       dataF;
    logic              stallF;
    logic              branch;
    addr_t             PCbranch;

    int errors;
    int checks;
    int lat;
    int wcnt;

    fetch_unit #(.PCINIT(64'h8000_0000)) dut (
        .clk      (clk),
        .reset    (reset),
        .ireq     (ireq),
        .iresp    (iresp),
        .dataF    (dataF),
        .stallF   (stallF),
        .branch   (branch),
        .PCbranch (PCbranch)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] instr_of(input addr_t a);
        return a[31:0] ^ 32'h0000_0013;
    endfunction

    // Responder: data_ok once a request has waited 'lat' cycles.
    task automatic tick();
        logic v;
        logic ok;
        iresp.addr_ok = ireq.valid;
        iresp.data_ok = ireq.valid && (wcnt >= lat);
        iresp.data    = {32'hCAFE_F00D, instr_of(ireq.addr)};
        v  = ireq.valid;
        ok = iresp.data_ok;
        @(posedge clk);
        if (reset) wcnt = 0;
        else if (v) wcnt = ok ? 0 : wcnt + 1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (dataF.valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", dataF.valid); end
        checks++; if (dataF.pc !== 64'd0) begin errors++; $display("FAIL rst_pc: got %h expected 0", dataF.pc); end
        checks++; if (dataF.raw_instr !== 32'd0) begin errors++; $display("FAIL rst_instr: got %h expected 0", dataF.raw_instr); end
        checks++; if (ireq.valid !== 1'b1) begin errors++; $display("FAIL rst_ireq_valid: got %b expected 1", ireq.valid); end
        checks++; if (ireq.addr !== 64'h8000_0000) begin errors++; $display("FAIL rst_ireq_addr: got %h expected 80000000", ireq.addr); end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        addr_t exp_pc;
        for (int k = 0; k < 3; k++) begin
            exp_pc = 64'h8000_0000 + 64'(4 * k);
            tick();
            checks++; if (dataF.valid !== 1'b0) begin errors++; $display("FAIL seq_gap%0d: got valid %b expected 0", k, dataF.valid); end
            tick();
            checks++; if (dataF.valid !== 1'b1 || dataF.pc !== exp_pc || dataF.raw_instr !== instr_of(exp_pc)) begin
                errors++; $display("FAIL seq_deliver%0d: got %b/%h/%h expected 1/%h/%h", k, dataF.valid, dataF.pc, dataF.raw_instr, exp_pc, instr_of(exp_pc));
            end
        end
        checks++; if (ireq.addr !== 64'h8000_000C) begin errors++; $display("FAIL seq_next_addr: got %h expected 8000000c", ireq.addr); end
    endtask

    task automatic test_stall_hold();
        stallF = 1'b1;
        tick();
        checks++; if (dataF.valid !== 1'b1 || dataF.pc !== 64'h8000_0008) begin errors++; $display("FAIL stall_hold1: got %b/%h expected 1/80000008", dataF.valid, dataF.pc); end
        tick();
        checks++; if (ireq.valid !== 1'b0) begin errors++; $display("FAIL hold_ireq_idle: got %b expected 0", ireq.valid); end
        checks++; if (dataF.valid !== 1'b1 || dataF.pc !== 64'h8000_0008) begin errors++; $display("FAIL stall_hold2: got %b/%h expected 1/80000008", dataF.valid, dataF.pc); end
        tick();
        checks++; if (ireq.valid !== 1'b0 || dataF.pc !== 64'h8000_0008) begin errors++; $display("FAIL stall_hold3: got %b/%h expected 0/80000008", ireq.valid, dataF.pc); end
        stallF = 1'b0;
        tick();
        checks++; if (dataF.valid !== 1'b1 || dataF.pc !== 64'h8000_000C || dataF.raw_instr !== instr_of(64'h8000_000C)) begin
            errors++; $display("FAIL hold_release: got %b/%h/%h expected 1/8000000c/%h", dataF.valid, dataF.pc, dataF.raw_instr, instr_of(64'h8000_000C));
        end
        checks++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0010) begin errors++; $display("FAIL hold_next_req: got %b/%h expected 1/80000010", ireq.valid, ireq.addr); end
    endtask

    task automatic test_branch_drop();
        lat = 4;
        branch = 1'b1;
        PCbranch = 64'h8000_1000;
        tick();
        branch = 1'b0;
        checks++; if (dataF.valid !== 1'b0) begin errors++; $display("FAIL drop_squash: got %b expected 0", dataF.valid); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0010) begin errors++; $display("FAIL drop_old_addr%0d: got %b/%h expected 1/80000010", k, ireq.valid, ireq.addr); end
            tick();
            checks++; if (dataF.valid !== 1'b0) begin errors++; $display("FAIL drop_no_deliver%0d: got %b expected 0", k, dataF.valid); end
        end
        tick();
        lat = 1;
        checks++; if (dataF.valid !== 1'b0 || ireq.addr !== 64'h8000_1000) begin errors++; $display("FAIL drop_exit: got %b/%h expected 0/80001000", dataF.valid, ireq.addr); end
        tick();
        tick();
        checks++; if (dataF.valid !== 1'b1 || dataF.pc !== 64'h8000_1000) begin errors++; $display("FAIL drop_target_deliver: got %b/%h expected 1/80001000", dataF.valid, dataF.pc); end
    endtask

    task automatic test_branch_stalled();
        lat = 3;
        stallF = 1'b1;
        branch = 1'b1;
        PCbranch = 64'h9000_0000;
        tick();
        checks++; if (ireq.addr !== 64'h8000_1004 || dataF.valid !== 1'b1 || dataF.pc !== 64'h8000_1000) begin
            errors++; $display("FAIL stalled_branch_ignored: got %h/%b/%h expected 80001004/1/80001000", ireq.addr, dataF.valid, dataF.pc);
        end
        stallF = 1'b0;
        tick();
        branch = 1'b0;
        lat = 1;
        checks++; if (dataF.valid !== 1'b0 || ireq.addr !== 64'h8000_1004) begin errors++; $display("FAIL rebranch_drop: got %b/%h expected 0/80001004", dataF.valid, ireq.addr); end
        tick();
        checks++; if (dataF.valid !== 1'b0 || ireq.addr !== 64'h9000_0000) begin errors++; $display("FAIL rebranch_target: got %b/%h expected 0/90000000", dataF.valid, ireq.addr); end
        tick();
        tick();
        checks++; if (dataF.valid !== 1'b1 || dataF.pc !== 64'h9000_0000 || dataF.raw_instr !== instr_of(64'h9000_0000)) begin
            errors++; $display("FAIL rebranch_deliver: got %b/%h/%h expected 1/90000000/%h", dataF.valid, dataF.pc, dataF.raw_instr, instr_of(64'h9000_0000));
        end
    endtask

    task automatic test_branch_with_data_ok();
        tick();
        branch = 1'b1;
        PCbranch = 64'hA000_0000;
        tick();
        branch = 1'b0;
        checks++; if (dataF.valid !== 1'b0 || ireq.addr !== 64'hA000_0000) begin errors++; $display("FAIL bdok_redirect: got %b/%h expected 0/a0000000", dataF.valid, ireq.addr); end
        tick();
        checks++; if (dataF.valid !== 1'b0) begin errors++; $display("FAIL bdok_no_wrong_path: got %b/%h expected valid 0", dataF.valid, dataF.pc); end
        tick();
        checks++; if (dataF.valid !== 1'b1 || dataF.pc !== 64'hA000_0000) begin errors++; $display("FAIL bdok_deliver: got %b/%h expected 1/a0000000", dataF.valid, dataF.pc); end
    endtask

    task automatic test_pc_wrap();
        branch = 1'b1;
        PCbranch = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        branch = 1'b0;
        tick();
        checks++; if (ireq.addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_target: got %h expected fffffffffffffffc", ireq.addr); end
        tick();
        tick();
        checks++; if (dataF.valid !== 1'b1 || dataF.pc !== 64'hFFFF_FFFF_FFFF_FFFC || dataF.raw_instr !== instr_of(64'hFFFF_FFFF_FFFF_FFFC)) begin
            errors++; $display("FAIL wrap_deliver: got %b/%h/%h expected 1/fffffffffffffffc/%h", dataF.valid, dataF.pc, dataF.raw_instr, instr_of(64'hFFFF_FFFF_FFFF_FFFC));
        end
        checks++; if (ireq.addr !== 64'd0) begin errors++; $display("FAIL wrap_next_pc: got %h expected 0", ireq.addr); end
    endtask

    task automatic test_reset_in_drop();
        lat = 5;
        branch = 1'b1;
        PCbranch = 64'h1234;
        tick();
        PCbranch = 64'h5678;
        tick();
        branch = 1'b0;
        checks++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'd0) begin errors++; $display("FAIL drop_rebranch_old: got %b/%h expected 1/0", ireq.valid, ireq.addr); end
        lat = 1;
        tick();
        checks++; if (ireq.addr !== 64'h5678) begin errors++; $display("FAIL drop_rebranch_pc: got %h expected 5678", ireq.addr); end
        lat = 5;
        branch = 1'b1;
        PCbranch = 64'h2000;
        tick();
        branch = 1'b0;
        checks++; if (ireq.addr !== 64'h5678 || dataF.valid !== 1'b0) begin errors++; $display("FAIL drop_enter2: got %h/%b expected 5678/0", ireq.addr, dataF.valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        lat = 1;
        checks++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0000 || dataF.valid !== 1'b0 || dataF.pc !== 64'd0) begin
            errors++; $display("FAIL drop_reset: got %b/%h/%b/%h expected 1/80000000/0/0", ireq.valid, ireq.addr, dataF.valid, dataF.pc);
        end
        tick();
        tick();
        checks++; if (dataF.valid !== 1'b1 || dataF.pc !== 64'h8000_0000) begin errors++; $display("FAIL post_reset_fetch: got %b/%h expected 1/80000000", dataF.valid, dataF.pc); end
    endtask

    initial begin
        clk      = 1'b0;
        reset    = 1'b1;
        stallF   = 1'b0;
        branch   = 1'b0;
        PCbranch = '0;
        iresp    = '0;
        lat      = 1;
        wcnt     = 0;
        errors   = 0;
        checks   = 0;
        test_reset();
        test_sequential();
        test_stall_hold();
        test_branch_drop();
        test_branch_stalled();
        test_branch_with_data_ok();
        test_pc_wrap();
        test_reset_in_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
